// File: rtl/regfile_read_port.sv
// Register file read port: captures two operand values per accepted address pair into a 2-entry output buffer.
// Latency: 1 cycle from accept to out_valid when the buffer is empty; one pair per cycle sustained.
// Backpressure: in_ready drops only when both entries are full (state-based, no combinational path from out_ready).
//
// Ports:
//   clk, reset (async active-low)
//   in_valid/in_ready, ra1/ra2     : address pair from decode
//   regs_flat                       : current register file contents, register i at [i*DATA_W +: DATA_W]
//   wr_en/wr_addr/wr_data           : register file write happening at this edge (forwarded and snooped)
//   out_valid/out_ready, rd1/rd2    : operand pair to execute, always driven from the HEAD entry
module regfile_read_port #(
    parameter int DATA_W   = 32,
    parameter int NREG     = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDR_W-1:0]      ra1,
    input  logic [ADDR_W-1:0]      ra2,
    input  logic [NREG*DATA_W-1:0] regs_flat,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [DATA_W-1:0]      wr_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      rd1,
    output logic [DATA_W-1:0]      rd2
);

    localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_REG);

    typedef struct packed {
        logic [ADDR_W-1:0] addr1;
        logic [ADDR_W-1:0] addr2;
        logic [DATA_W-1:0] data1;
        logic [DATA_W-1:0] data2;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state;
    entry_t head;
    entry_t skid;

    logic [DATA_W-1:0] regs [NREG];

    for (genvar g = 0; g < NREG; g++) begin : g_unpack
        assign regs[g] = regs_flat[g*DATA_W +: DATA_W];
    end

    // A write to the zero register never reaches any stored entry.
    logic snoop_en;
    assign snoop_en = wr_en && (wr_addr != ZADDR);

    // Read rule: zero register wins, then the same-edge write, then the array.
    function automatic logic [DATA_W-1:0] read_val(input logic [ADDR_W-1:0] a);
        if (a == ZADDR)
            return '0;
        else if (wr_en && (wr_addr == a))
            return wr_data;
        else
            return regs[a];
    endfunction

    // Keep a held entry coherent with the write landing at this edge.
    function automatic entry_t snoop(input entry_t e);
        entry_t r;
        r = e;
        if (snoop_en && (e.addr1 == wr_addr)) r.data1 = wr_data;
        if (snoop_en && (e.addr2 == wr_addr)) r.data2 = wr_data;
        return r;
    endfunction

    entry_t new_entry;
    entry_t head_snp;
    entry_t skid_snp;

    always_comb begin
        new_entry       = '0;
        new_entry.addr1 = ra1;
        new_entry.addr2 = ra2;
        new_entry.data1 = read_val(ra1);
        new_entry.data2 = read_val(ra2);
        head_snp        = snoop(head);
        skid_snp        = snoop(skid);
    end

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);

    logic acc;
    logic pop;
    assign acc = in_valid && in_ready;
    assign pop = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
            head  <= '0;
            skid  <= '0;
        end else begin
            // Default: hold, but let the snoop refresh matching fields.
            head <= head_snp;
            skid <= skid_snp;
            case (state)
                EMPTY: begin
                    if (acc) begin
                        head  <= new_entry;
                        state <= ONE;
                    end
                end
                ONE: begin
                    if (acc && !pop) begin
                        skid  <= new_entry;
                        state <= TWO;
                    end else if (acc && pop) begin
                        head  <= new_entry;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    // SKID moves up already carrying this edge's write.
                    if (pop) begin
                        head  <= skid_snp;
                        state <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign rd1 = head.data1;
    assign rd2 = head.data2;

endmodule

// File: tb/tb_regfile_read_port.sv
module tb_regfile_read_port;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    ra1, ra2;
    logic [1023:0] regs_flat;
    logic          wr_en;
    logic [4:0]    wr_addr;
    logic [31:0]   wr_data;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   rd1, rd2;

    logic [31:0] regs [32];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < 32; i++) regs_flat[i*32 +: 32] = regs[i];
    end

    regfile_read_port dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ra1       (ra1),
        .ra2       (ra2),
        .regs_flat (regs_flat),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rd1       (rd1),
        .rd2       (rd2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of at most two pending operand pairs.
    typedef struct {
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] d1;
        logic [31:0] d2;
    } pair_t;

    pair_t mq[$];
    pair_t np;
    bit    m_acc, m_pop;

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd31) return 32'h0;
        if (wr_en && wr_addr == a) return wr_data;
        return regs[a];
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
        end else begin
            m_acc = in_valid && (mq.size() < 2);
            m_pop = (mq.size() > 0) && out_ready;
            if (wr_en && wr_addr != 5'd31) begin
                foreach (mq[i]) begin
                    if (mq[i].a1 == wr_addr) mq[i].d1 = wr_data;
                    if (mq[i].a2 == wr_addr) mq[i].d2 = wr_data;
                end
            end
            if (m_pop) void'(mq.pop_front());
            if (m_acc) begin
                np.a1 = ra1;
                np.a2 = ra2;
                np.d1 = model_read(ra1);
                np.d2 = model_read(ra2);
                mq.push_back(np);
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("out_valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
        check("in_ready", {31'b0, in_ready}, {31'b0, mq.size() < 2});
        if (mq.size() != 0) begin
            check("rd1", rd1, mq[0].d1);
            check("rd2", rd2, mq[0].d2);
        end
    end

    // Advance one clock and settle just after the edge; the regfile itself
    // commits any write at that edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (wr_en && wr_addr != 5'd31) regs[wr_addr] = wr_data;
    endtask

    task automatic offer(input logic [4:0] a1, input logic [4:0] a2);
        in_valid = 1'b1;
        ra1      = a1;
        ra2      = a2;
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        ra1       = '0;
        ra2       = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 32; i++) regs[i] = 32'h1000 + i;
        regs[3]  = 32'h33;
        regs[5]  = 32'h1111;
        regs[7]  = 32'h77;
        regs[9]  = 32'h9;
        regs[10] = 32'h10A;
        regs[31] = 32'hFFFF_FFFF;

        // Reset release and first read.
        repeat (3) tick();
        reset = 1'b1;
        #1;
        check("rst out_valid", {31'b0, out_valid}, 32'd0);
        check("rst in_ready", {31'b0, in_ready}, 32'd1);
        check("rst rd1", rd1, 32'h0);
        check("rst rd2", rd2, 32'h0);
        tick();
        offer(5'd3, 5'd7);
        tick();
        in_valid = 1'b0;
        check("read rd1", rd1, 32'h33);
        check("read rd2", rd2, 32'h77);
        check("read out_valid", {31'b0, out_valid}, 32'd1);

        // Zero register ignores both the array and a same-edge write.
        offer(5'd31, 5'd31);
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h1234;
        tick();
        wr_en = 1'b0;
        in_valid = 1'b0;
        check("zero rd1", rd1, 32'h0);
        check("zero rd2", rd2, 32'h0);

        // Same-edge forwarding.
        offer(5'd5, 5'd2);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hABCD;
        tick();
        wr_en = 1'b0;
        in_valid = 1'b0;
        check("fwd rd1", rd1, 32'hABCD);
        check("fwd rd2", rd2, 32'h1002);
        tick();

        // Backpressure fill: A, B accepted, C refused until space frees.
        out_ready = 1'b0;
        offer(5'd1, 5'd2);
        tick();
        check("fill A in_ready", {31'b0, in_ready}, 32'd1);
        offer(5'd3, 5'd4);
        tick();
        check("fill B in_ready", {31'b0, in_ready}, 32'd0);
        offer(5'd6, 5'd8);
        tick();
        check("fill C refused", {31'b0, in_ready}, 32'd0);
        check("fill head A", rd1, 32'h1001);
        out_ready = 1'b1;
        tick();
        check("drain B", rd1, 32'h33);
        check("drain B rd2", rd2, 32'h1004);
        tick();
        in_valid = 1'b0;
        check("drain C", rd1, 32'h1006);
        check("drain C rd2", rd2, 32'h1008);
        tick();
        check("drain empty", {31'b0, out_valid}, 32'd0);

        // Snoop while stalled.
        out_ready = 1'b0;
        offer(5'd9, 5'd10);
        tick();
        offer(5'd1, 5'd9);
        tick();
        in_valid = 1'b0;
        check("snoop old", rd1, 32'h9);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
        tick();
        wr_en = 1'b0;
        check("snoop head r9", rd1, 32'h99);
        check("snoop head r10", rd2, 32'h10A);
        out_ready = 1'b1;
        tick();
        check("snoop skid r1", rd1, 32'h1001);
        check("snoop skid r9", rd2, 32'h99);
        tick();

        // Write landing exactly as SKID moves into HEAD.
        out_ready = 1'b0;
        offer(5'd11, 5'd12);
        tick();
        offer(5'd13, 5'd14);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd14; wr_data = 32'hC0DE;
        tick();
        wr_en = 1'b0;
        check("move snoop rd2", rd2, 32'hC0DE);
        tick();

        // Reset pulse while full.
        out_ready = 1'b0;
        offer(5'd11, 5'd12);
        tick();
        offer(5'd13, 5'd14);
        tick();
        in_valid = 1'b0;
        check("pre-reset full", {31'b0, in_ready}, 32'd0);
        #1;
        reset = 1'b0;
        #1;
        check("async out_valid", {31'b0, out_valid}, 32'd0);
        check("async in_ready", {31'b0, in_ready}, 32'd1);
        check("async rd1", rd1, 32'h0);
        reset = 1'b1;
        out_ready = 1'b1;
        offer(5'd15, 5'd16);
        tick();
        in_valid = 1'b0;
        check("post-reset rd1", rd1, 32'h100F);
        check("post-reset valid", {31'b0, out_valid}, 32'd1);
        tick();
        check("post-reset alone", {31'b0, out_valid}, 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
